// File: rtl/dp_mem_bank.sv
// dp_mem_bank: dual-port memory bank with a hardware clear sequencer.
//   Port A reads and writes with byte enables. Port B is read-only.
//   Both ports can be used in the same cycle.
//   Read latency is 1 + OUT_REG cycles. rvalid pulses for one cycle; rdata holds between reads.
//   A clear sweep zero-fills the array after reset (INIT_CLEAR) or on a clr_req pulse.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   clr_req, ready  clear request (honoured only in RUN); ready is high while in RUN
//   a_*             port A: addr, we, be, wdata, re -> rdata, rvalid
//   b_*             port B: addr, re -> rdata, rvalid
module dp_mem_bank #(
  parameter int unsigned WORD       = 32,
  parameter int unsigned ADDR       = 16,
  parameter int unsigned DEPTH      = 65536,
  parameter int unsigned OUT_REG    = 0,
  parameter int unsigned INIT_CLEAR = 1,
  parameter int unsigned RDW_MODE   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req,
  output logic              ready,
  input  logic [ADDR-1:0]   a_addr,
  input  logic              a_we,
  input  logic [WORD/8-1:0] a_be,
  input  logic [WORD-1:0]   a_wdata,
  input  logic              a_re,
  output logic [WORD-1:0]   a_rdata,
  output logic              a_rvalid,
  input  logic [ADDR-1:0]   b_addr,
  input  logic              b_re,
  output logic [WORD-1:0]   b_rdata,
  output logic              b_rvalid
);

  localparam int unsigned NB   = WORD / 8;
  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DEPTH - 1);

  typedef enum logic [0:0] {StClear, StRun} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] cnt_q, cnt_d;
  logic [WORD-1:0] mem [DEPTH];

  logic            run;
  logic            a_in_range, b_in_range;
  logic [IdxW-1:0] a_idx, b_idx;
  logic            a_wr_fire, a_rd_fire, b_rd_fire, collide;
  logic            mem_we;
  logic [IdxW-1:0] mem_idx;
  logic [NB-1:0]   mem_be;
  logic [WORD-1:0] mem_wdata;
  logic [WORD-1:0] a_rd_word, b_rd_word, b_merged;

  logic [WORD-1:0] a_s1_data_q, b_s1_data_q;
  logic            a_s1_valid_q, b_s1_valid_q;

  // Gating with rst_n keeps ready low and blocks writes for as long as reset is held.
  assign run   = rst_n && (state_q == StRun);
  assign ready = run;

  assign a_idx      = a_addr[IdxW-1:0];
  assign b_idx      = b_addr[IdxW-1:0];
  assign a_in_range = (32'(a_addr) < DEPTH);
  assign b_in_range = (32'(b_addr) < DEPTH);

  // Write has priority over read on port A.
  assign a_wr_fire = run && a_we;
  assign a_rd_fire = run && a_re && !a_we;
  assign b_rd_fire = run && b_re;
  assign collide   = a_wr_fire && a_in_range && (a_addr == b_addr);

  // Clear sequencer
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StClear: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastIdx) begin
          state_d = StRun;
          cnt_d   = '0;
        end
      end
      StRun: begin
        if (clr_req) begin
          state_d = StClear;
          cnt_d   = '0;
        end
      end
      default: state_d = StClear;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= (INIT_CLEAR != 0) ? StClear : StRun;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Array write port, shared between the sweep and port A.
  always_comb begin
    mem_we    = 1'b0;
    mem_idx   = a_idx;
    mem_be    = a_be;
    mem_wdata = a_wdata;
    if (rst_n && (state_q == StClear)) begin
      mem_we    = 1'b1;
      mem_idx   = cnt_q;
      mem_be    = '1;
      mem_wdata = '0;
    end else if (a_wr_fire && a_in_range) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < NB; i++) begin
        if (mem_be[i]) mem[mem_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
  end

  // Read data selection, including the read-during-write bypass for port B.
  always_comb begin
    b_merged = mem[b_idx];
    for (int i = 0; i < NB; i++) begin
      if (a_be[i]) b_merged[8*i +: 8] = a_wdata[8*i +: 8];
    end
    a_rd_word = a_in_range ? mem[a_idx] : '0;
    b_rd_word = '0;
    if (b_in_range) b_rd_word = ((RDW_MODE != 0) && collide) ? b_merged : mem[b_idx];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_s1_data_q  <= '0;
      a_s1_valid_q <= 1'b0;
      b_s1_data_q  <= '0;
      b_s1_valid_q <= 1'b0;
    end else begin
      a_s1_valid_q <= a_rd_fire;
      b_s1_valid_q <= b_rd_fire;
      if (a_rd_fire) a_s1_data_q <= a_rd_word;
      if (b_rd_fire) b_s1_data_q <= b_rd_word;
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [WORD-1:0] a_s2_data_q, b_s2_data_q;
    logic            a_s2_valid_q, b_s2_valid_q;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        a_s2_data_q  <= '0;
        a_s2_valid_q <= 1'b0;
        b_s2_data_q  <= '0;
        b_s2_valid_q <= 1'b0;
      end else begin
        a_s2_valid_q <= a_s1_valid_q;
        b_s2_valid_q <= b_s1_valid_q;
        if (a_s1_valid_q) a_s2_data_q <= a_s1_data_q;
        if (b_s1_valid_q) b_s2_data_q <= b_s1_data_q;
      end
    end

    assign a_rdata  = a_s2_data_q;
    assign a_rvalid = a_s2_valid_q;
    assign b_rdata  = b_s2_data_q;
    assign b_rvalid = b_s2_valid_q;
  end else begin : g_no_out_reg
    assign a_rdata  = a_s1_data_q;
    assign a_rvalid = a_s1_valid_q;
    assign b_rdata  = b_s1_data_q;
    assign b_rvalid = b_s1_valid_q;
  end

endmodule

// File: tb/tb_dp_mem_bank.sv
// Testbench for dp_mem_bank. Three instances share one stimulus stream:
//   u0: DEPTH=16, OUT_REG=0, RDW_MODE=0
//   u1: DEPTH=16, OUT_REG=1, RDW_MODE=1
//   u2: DEPTH=12, OUT_REG=0, RDW_MODE=0 (addresses 12..15 out of range)
module tb_dp_mem_bank;

  logic        clk = 1'b0;
  logic        rst_n, clr_req, a_we, a_re, b_re;
  logic [3:0]  a_addr, b_addr, a_be;
  logic [31:0] a_wdata;

  logic        rdy0, rdy1, rdy2, arv0, arv1, arv2, brv0, brv1, brv2;
  logic [31:0] ard0, ard1, ard2, brd0, brd1, brd2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dp_mem_bank #(.WORD(32), .ADDR(4), .DEPTH(16), .OUT_REG(0), .INIT_CLEAR(1), .RDW_MODE(0)) u0 (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .ready(rdy0),
    .a_addr(a_addr), .a_we(a_we), .a_be(a_be), .a_wdata(a_wdata), .a_re(a_re),
    .a_rdata(ard0), .a_rvalid(arv0), .b_addr(b_addr), .b_re(b_re),
    .b_rdata(brd0), .b_rvalid(brv0)
  );

  dp_mem_bank #(.WORD(32), .ADDR(4), .DEPTH(16), .OUT_REG(1), .INIT_CLEAR(1), .RDW_MODE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .ready(rdy1),
    .a_addr(a_addr), .a_we(a_we), .a_be(a_be), .a_wdata(a_wdata), .a_re(a_re),
    .a_rdata(ard1), .a_rvalid(arv1), .b_addr(b_addr), .b_re(b_re),
    .b_rdata(brd1), .b_rvalid(brv1)
  );

  dp_mem_bank #(.WORD(32), .ADDR(4), .DEPTH(12), .OUT_REG(0), .INIT_CLEAR(1), .RDW_MODE(0)) u2 (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .ready(rdy2),
    .a_addr(a_addr), .a_we(a_we), .a_be(a_be), .a_wdata(a_wdata), .a_re(a_re),
    .a_rdata(ard2), .a_rvalid(arv2), .b_addr(b_addr), .b_re(b_re),
    .b_rdata(brd2), .b_rvalid(brv2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Inputs set before the call are sampled at the next edge; outputs are read 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_we    = 1'b0;
    a_re    = 1'b0;
    b_re    = 1'b0;
    clr_req = 1'b0;
    a_be    = 4'h0;
  endtask

  task automatic write(input logic [3:0] ad, input logic [31:0] d, input logic [3:0] be);
    a_addr  = ad;
    a_wdata = d;
    a_be    = be;
    a_we    = 1'b1;
    step();
    idle();
  endtask

  // Cycles until u0 raises ready; -1 if it never does within the budget.
  task automatic wait_ready(output int n);
    n = -1;
    for (int i = 1; i <= 64; i++) begin
      step();
      if (rdy0) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    int          n, cnt0, cnt2, nv0, nv1, nv2;
    logic        saw_v;
    logic [31:0] or0, or1, or2;

    rst_n = 1'b0; idle(); a_addr = '0; b_addr = '0; a_wdata = '0;
    step(); step();
    check("rst_ready0", 32'(rdy0), 32'd0);
    check("rst_rvalid", 32'({arv0, brv0, arv1, brv1}), 32'd0);
    check("rst_rdata0", ard0 | brd0, 32'd0);
    check("rst_rdata1", ard1 | brd1, 32'd0);

    // Initial sweep with requests held during the first 10 cycles; they must be ignored.
    rst_n = 1'b1; cnt0 = -1; cnt2 = -1; saw_v = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      if (i <= 10) begin
        a_addr = 4'd0; a_wdata = 32'hFFFF_FFFF; a_be = 4'hF; a_we = 1'b1;
        b_addr = 4'd1; b_re = 1'b1;
      end else begin
        idle();
      end
      step();
      if (arv0 | arv1 | arv2 | brv0 | brv1 | brv2) saw_v = 1'b1;
      if (rdy2 && cnt2 < 0) cnt2 = i;
      if (rdy0) begin
        cnt0 = i;
        break;
      end
    end
    check("sweep_len16", 32'(cnt0), 32'd16);
    check("sweep_len12", 32'(cnt2), 32'd12);
    check("gated_rvalid", 32'(saw_v), 32'd0);
    check("ready_u1", 32'(rdy1), 32'd1);

    // Back-to-back B reads of every address.
    nv0 = 0; nv1 = 0; nv2 = 0; or0 = '0; or1 = '0; or2 = '0;
    for (int k = 0; k < 18; k++) begin
      if (k < 16) begin
        b_addr = 4'(k); b_re = 1'b1;
      end else begin
        b_re = 1'b0;
      end
      step();
      if (k == 0) check("b_lat", 32'({brv0, brv1}), 32'b10);
      if (brv0) begin nv0++; or0 |= brd0; end
      if (brv1) begin nv1++; or1 |= brd1; end
      if (brv2) begin nv2++; or2 |= brd2; end
    end
    check("clr_pulses0", 32'(nv0), 32'd16);
    check("clr_pulses1", 32'(nv1), 32'd16);
    check("clr_pulses2", 32'(nv2), 32'd16);
    check("clr_data0", or0, 32'd0);
    check("clr_data1", or1, 32'd0);
    check("clr_data2", or2, 32'd0);

    // Byte enables.
    write(4'd3, 32'hAABB_CCDD, 4'hF);
    write(4'd3, 32'h1122_3344, 4'h5);
    a_addr = 4'd3; a_re = 1'b1; step(); idle();
    check("be_v0", 32'(arv0), 32'd1);
    check("be_d0", ard0, 32'hAA22_CC44);
    check("be_v1_early", 32'(arv1), 32'd0);
    check("be_d2", ard2, 32'hAA22_CC44);
    step();
    check("be_v0_pulse", 32'(arv0), 32'd0);
    check("be_d0_hold", ard0, 32'hAA22_CC44);
    check("be_v1", 32'(arv1), 32'd1);
    check("be_d1", ard1, 32'hAA22_CC44);

    // Same-address collision: A writes addr 5 while B reads it.
    a_addr = 4'd5; a_wdata = 32'hDEAD_BEEF; a_be = 4'hF; a_we = 1'b1;
    b_addr = 4'd5; b_re = 1'b1;
    step(); idle();
    check("col_v0", 32'(brv0), 32'd1);
    check("col_d0", brd0, 32'h0000_0000);
    check("col_d2", brd2, 32'h0000_0000);
    step();
    check("col_v1", 32'(brv1), 32'd1);
    check("col_d1", brd1, 32'hDEAD_BEEF);

    // a_be=0 leaves the word unchanged.
    write(4'd5, 32'hFFFF_FFFF, 4'h0);
    b_addr = 4'd5; b_re = 1'b1; step(); idle();
    check("be0_d0", brd0, 32'hDEAD_BEEF);
    step();
    check("be0_d1", brd1, 32'hDEAD_BEEF);

    // Write has priority over read on port A.
    a_addr = 4'd6; a_wdata = 32'h55AA_55AA; a_be = 4'hF; a_we = 1'b1; a_re = 1'b1;
    step(); idle();
    check("prio_v0", 32'(arv0), 32'd0);
    step();
    check("prio_v1", 32'(arv1), 32'd0);
    a_addr = 4'd6; a_re = 1'b1; step(); idle();
    check("prio_d0", ard0, 32'h55AA_55AA);
    step();
    check("prio_d1", ard1, 32'h55AA_55AA);

    // Out of range for u2 only.
    write(4'd14, 32'hCAFE_F00D, 4'hF);
    a_re = 1'b1;
    a_addr = 4'd14; step();
    check("oor_v2", 32'(arv2), 32'd1);
    check("oor_d2", ard2, 32'd0);
    check("inr_d0", ard0, 32'hCAFE_F00D);
    a_addr = 4'd2; step();
    check("oor_alias2", ard2, 32'd0);
    a_addr = 4'd6; step();
    check("oor_alias6", ard2, 32'h55AA_55AA);
    idle();

    // clr_req: same-cycle read still serviced, then the array is zeroed.
    write(4'd9, 32'h0000_1234, 4'hF);
    a_addr = 4'd9; a_re = 1'b1; clr_req = 1'b1; step(); idle();
    check("clr_same_v0", 32'(arv0), 32'd1);
    check("clr_same_d0", ard0, 32'h0000_1234);
    check("clr_ready", 32'(rdy0), 32'd0);
    wait_ready(n);
    check("clr_len", 32'(n), 32'd16);
    a_addr = 4'd9; a_re = 1'b1; step(); idle();
    check("clr_d0", ard0, 32'd0);
    step();
    check("clr_d1", ard1, 32'd0);

    // In-flight read in u1's output stage is dropped by reset.
    a_addr = 4'd3; a_re = 1'b1; step();
    idle(); rst_n = 1'b0; step();
    check("flush_v1", 32'(arv1), 32'd0);
    check("flush_ready", 32'(rdy0), 32'd0);

    // Reset at cnt=7 restarts the sweep from zero.
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) step();
    check("mid_ready", 32'(rdy0), 32'd0);
    rst_n = 1'b0; step();
    rst_n = 1'b1;
    wait_ready(n);
    check("mid_len", 32'(n), 32'd16);
    a_addr = 4'd3; a_re = 1'b1; step(); idle();
    check("mid_d0", ard0, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dp_mem_bank.md
Name: dp_mem_bank

Overview:
- Parametrised successor to the team's single-port 32x64k memory model.
- Port A reads and writes, with byte enables; port B is read-only. Both ports work in the same cycle.
- Adds per-port read-valid strobes, an optional output register stage, and a defined read-during-write policy.
- A hardware clear sequencer zero-fills the array after reset or on request. It sits between the core load/store units and the backing store.

Parameters:
- WORD, 32, data width in bits; must be a multiple of 8.
- ADDR, 16, address width in bits.
- DEPTH, 65536, number of words; DEPTH <= 2**ADDR.
- OUT_REG, 0, 0 = read latency 1; 1 = extra output register stage, read latency 2.
- INIT_CLEAR, 1, 1 = run a clear sweep after reset; 0 = go straight to RUN with array contents undefined.
- RDW_MODE, 0, same-address port-B read during a port-A write: 0 = B returns old data; 1 = B returns new (merged) data.

Ports:
- clk, in, 1, single clock; all logic on posedge.
- rst_n, in, 1, synchronous active-low reset.
- clr_req, in, 1, pulse requesting a clear sweep; honoured only in RUN.
- ready, out, 1, high when requests are accepted (RUN state).
- a_addr, in, ADDR, port A address.
- a_we, in, 1, port A write strobe.
- a_be, in, WORD/8, port A byte enables; bit i covers bits [8i+7:8i].
- a_wdata, in, WORD, port A write data.
- a_re, in, 1, port A read strobe.
- a_rdata, out, WORD, port A read data.
- a_rvalid, out, 1, one-cycle pulse: a_rdata valid.
- b_addr, in, ADDR, port B address.
- b_re, in, 1, port B read strobe.
- b_rdata, out, WORD, port B read data.
- b_rvalid, out, 1, one-cycle pulse: b_rdata valid.

Behaviour:
- Reset (rst_n=0 sampled at posedge):
  - ready=0, a_rvalid=b_rvalid=0, a_rdata=b_rdata=0.
  - Output pipeline is flushed; clear counter is set to 0.
  - Array contents are not touched by reset itself.
- FSM states:
  - CLEAR: ready=0. Writes 0 to address cnt each cycle, then cnt++. After writing DEPTH-1, the next cycle enters RUN (ready=1). A sweep takes exactly DEPTH cycles.
  - RUN: ready=1. clr_req=1 -> CLEAR with cnt=0 next cycle. Requests sampled in the same cycle as clr_req are still serviced.
  - After reset: CLEAR if INIT_CLEAR=1, else RUN.
- While ready=0, all a_we/a_re/b_re are ignored: no array write, no rvalid.
- Reset asserted mid-sweep aborts the sweep; after release the sweep restarts at cnt=0. Any in-flight rvalid is dropped.
- Port A write (RUN, a_we=1):
  - Only bytes with a_be[i]=1 are updated.
  - a_be=0 leaves the word unchanged.
- Port A read:
  - a_we has priority. a_we=1 with a_re=1 performs the write only; no a_rvalid.
  - Otherwise a_re=1 returns the stored word with a_rvalid after 1+OUT_REG cycles.
- Port B read: b_re=1 returns data with b_rvalid after 1+OUT_REG cycles.
- Collision (a_we=1 and b_re=1 with a_addr==b_addr):
  - RDW_MODE=0: b_rdata = pre-write word.
  - RDW_MODE=1: b_rdata = byte-merged post-write word.
- Out-of-range address (addr >= DEPTH):
  - Writes are dropped.
  - Reads return 0 with rvalid asserted normally.
- rdata holds its last value between valid reads. rvalid is high only in the valid cycle. Back-to-back reads give one result per cycle with no bubbles.
- Ports are fully pipelined and independent; no backpressure.

Test Plan:
- Reset/clear (DEPTH=16, INIT_CLEAR=1):
  - Release rst_n -> ready stays 0 for exactly 16 cycles, then 1.
  - Read every address via B -> all 0, b_rvalid pulse each.
- Byte enables:
  - Write 0xAABBCCDD to addr 3 with a_be=4'b1111, then 0x11223344 with a_be=4'b0101.
  - Read addr 3 on A -> 0xAA22CC44, a_rvalid exactly 1 cycle after a_re (OUT_REG=0) and 2 cycles after (OUT_REG=1).
- Collision:
  - addr 5 holds 0x0; A writes 0xDEADBEEF (be=all) while B reads addr 5.
  - RDW_MODE=0 -> b_rdata=0x00000000; RDW_MODE=1 -> 0xDEADBEEF.
- A priority and gating:
  - a_we=a_re=1 -> write lands, a_rvalid stays 0.
  - Requests issued while ready=0 -> no write, no rvalid.
- Mid-sweep reset:
  - Pulse rst_n low at cnt=7 -> ready rises exactly 16 cycles after release.
  - clr_req in RUN after writing 0x1234 to addr 9 -> addr 9 reads 0 after ready returns.
- Out of range (DEPTH=12, ADDR=4):
  - Write addr 14 is dropped; read addr 14 -> 0 with rvalid.
  - Addresses 0..11 are unaffected.
